result_sender: RTL and testbench
================================

Name: result_sender

Overview:
- Downstream consumer of the processing FSM's SENDING state. Launched by a one-cycle start pulse when the FSM enters SENDING.
- Reads output-layer results from the result memory and streams them over a narrow valid/ready output port.
- Classification mode: first reduces the results to the argmax index, then sends only that index.
- Pulses done_sending back to the FSM once the last beat is accepted.

Parameters:
- DATA_WIDTH, 16, width of one result word (signed two's complement).
- OUT_WIDTH, 4, output bus width; DATA_WIDTH must be a multiple of OUT_WIDTH.
- ADDR_WIDTH, 6, result memory address width; up to 2^ADDR_WIDTH results.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse: begin a send job.
- classification  in  1  sampled at start; 1 = send argmax index only.
- num_outputs_m1  in  ADDR_WIDTH  result count minus one; sampled at start.
- rd_en  out  1  result memory read strobe.
- rd_addr  out  ADDR_WIDTH  result memory read address.
- rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en.
- out_data  out  OUT_WIDTH  output beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  sink accepts beat.
- busy  out  1  high from the cycle after start until the done_sending cycle inclusive.
- done_sending  out  1  one-cycle pulse: job complete.

Behaviour:
- Reset: state IDLE. rd_en, rd_addr, out_data, out_valid, busy and done_sending are all 0. Internal counters, max register and shift register are cleared. Reset mid-job aborts immediately with no done_sending pulse.
- Interface: clk, one clock domain; rst is synchronous and active-high.
- States: IDLE, SCAN, FETCH, LOAD, SHIFT, DONE.
- Start handling: start is accepted only in IDLE and ignored while busy. At acceptance (cycle T) the block latches classification and num_outputs_m1 (N = num_outputs_m1 + 1).
- Classification transitions to SCAN:
  - rd_en is high cycles T+1..T+N with rd_addr = 0..N-1, one read per cycle.
  - Each returned word is compared as signed (strictly greater replaces). The running max is initialised from address 0, so ties keep the lowest index.
  - After the last compare (cycle T+N+1), the index is zero-extended to DATA_WIDTH and loaded into the shift register. Go to SHIFT; out_valid rises at T+N+2.
- Non-classification transitions to FETCH:
  - rd_en is high for one cycle with the current address, then LOAD captures rd_data into the shift register, then SHIFT.
  - First out_valid is at T+3.
- SHIFT:
  - out_data is the MS OUT_WIDTH bits of the shift register.
  - Beats per word B = DATA_WIDTH/OUT_WIDTH, sent MS chunk first.
  - A beat transfers when out_valid && out_ready. On transfer, shift left by OUT_WIDTH.
  - out_valid stays high and out_data stays stable while out_ready is low; valid is never withdrawn.
  - After beat B of a word: if more words remain (non-classification), increment the address and go to FETCH, with valid low for 2 cycles. Otherwise go to DONE.
- DONE: done_sending=1 and busy=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- Address counter wraps nowhere: the maximum N = 2^ADDR_WIDTH ends at address 2^ADDR_WIDTH-1.
- Classification with N=1: index 0 is sent with no compare.
- start and rst in the same cycle: rst wins.

Test Plan:
- Non-classification, N=2, mem[0]=0x1234, mem[1]=0xABCD, out_ready=1 -> beats 1,2,3,4,A,B,C,D. First valid at T+3. done_sending single pulse one cycle after the D beat.
- Classification, N=4, mem = {5, -3, 0x7FFF, 0x7FFF} -> argmax index 2 (tie keeps lowest). Beats 0,0,0,2, first valid at T+6. rd_en high T+1..T+4.
- Backpressure: out_ready toggled 0/1 randomly during the first test -> same beat sequence, data stable while stalled, no beat duplicated or lost.
- Negative values, classification, N=3, mem = {0x8000, 0xFFFF, 0xFFFE} -> index 1 (-1 is max). Beats 0,0,0,1.
- Start while busy, plus max N = 64 non-classification -> second start ignored. Exactly 256 beats, last rd_addr=63, one done_sending.
- rst asserted mid-SHIFT -> next cycle out_valid=0, busy=0, no done_sending. A new start afterwards runs a clean job.

Source files
------------

// File: rtl/result_sender.sv
// Streams output-layer results from the result memory over a narrow valid/ready port.
// In classification mode the results are first reduced to their argmax index, which is sent alone.
module result_sender #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OUT_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  classification,
  input  logic [ADDR_WIDTH-1:0] num_outputs_m1,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done_sending
);

  localparam int unsigned BEATS  = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  cls_q, cls_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [ADDR_WIDTH-1:0] max_idx_q, max_idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  take;
  logic [DATA_WIDTH-1:0] cand_max;
  logic [ADDR_WIDTH-1:0] cand_idx;

  // Running argmax: address 0 seeds the max, later words replace only when strictly greater.
  always_comb begin
    take     = (rd_idx_q == '0) || ($signed(rd_data) > $signed(max_q));
    cand_max = take ? rd_data  : max_q;
    cand_idx = take ? rd_idx_q : max_idx_q;
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    last_d    = last_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_vld_d  = rd_en_q;
    rd_idx_d  = rd_addr_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    sh_d      = sh_q;
    beat_d    = beat_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cls_d     = classification;
          last_d    = num_outputs_m1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          beat_d    = '0;
          state_d   = classification ? SCAN : FETCH;
        end
      end
      SCAN: begin
        rd_en_d = rd_en_q && (rd_addr_q != last_q);
        if (rd_en_d) begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
        if (rd_vld_q) begin
          max_d     = cand_max;
          max_idx_d = cand_idx;
          if (rd_idx_q == last_q) begin
            sh_d    = DATA_WIDTH'(cand_idx);
            beat_d  = '0;
            state_d = SHIFT;
          end
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        sh_d    = rd_data;
        beat_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (out_valid_q && out_ready) begin
          sh_d   = sh_q << OUT_WIDTH;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (!cls_q && (rd_addr_q != last_q)) begin
              rd_en_d   = 1'b1;
              rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
              state_d   = FETCH;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == SHIFT);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cls_q       <= 1'b0;
      last_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      max_q       <= '0;
      max_idx_q   <= '0;
      sh_q        <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      last_q      <= last_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_idx_q    <= rd_idx_d;
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
      sh_q        <= sh_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign out_data     = sh_q[DATA_WIDTH-1 -: OUT_WIDTH];
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign done_sending = done_q;

endmodule

// File: tb/tb_result_sender.sv
// Directed bench for result_sender: a behavioural result memory feeds the DUT and every
// beat, read strobe and handshake timing is checked against hand-computed values.
module tb_result_sender;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        classification;
  logic [5:0]  num_outputs_m1;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done_sending;

  result_sender #(.DATA_WIDTH(16), .OUT_WIDTH(4), .ADDR_WIDTH(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .classification (classification),
    .num_outputs_m1 (num_outputs_m1),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .done_sending   (done_sending)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [64];

  // Read data returns exactly one cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  beats [$];
  logic [15:0] exp_w [$];
  int          first_valid, first_rd, last_rd, n_rd, n_done, done_cyc, last_beat_cyc;
  logic [5:0]  last_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one job from IDLE and record what the DUT does until a few cycles after done_sending.
  task automatic run_job(input bit cls, input int nm1, input bit bp, input int restart_at);
    int   c;
    int   post;
    logic prev_valid, prev_ready;
    logic [3:0] prev_data;
    beats.delete();
    first_valid = -1; first_rd = -1; last_rd = -1; n_rd = 0; n_done = 0;
    done_cyc = -1; last_beat_cyc = -1; last_addr = '0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
    classification = cls;
    num_outputs_m1 = 6'(nm1);
    start = 1'b1;
    out_ready = 1'b1;
    c = 0;
    post = 0;
    while (post < 4 && c < 3000) begin
      @(posedge clk); #1;
      c++;
      start = (c == restart_at);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_valid && !prev_ready) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (rd_en) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        n_rd++;
        last_addr = rd_addr;
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = c;
        if (out_ready) begin
          beats.push_back(out_data);
          last_beat_cyc = c;
        end
      end
      if (n_done > 0) begin
        post++;
        check("busy_after_done", 32'(busy), 32'd0);
      end
      if (done_sending) begin
        n_done++;
        done_cyc = c;
        check("busy_at_done", 32'(busy), 32'd1);
      end
      if (c == 1) check("busy_t1", 32'(busy), 32'd1);
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("done_count", 32'(n_done), 32'd1);
    check("done_after_last_beat", 32'(done_cyc), 32'(last_beat_cyc + 1));
  endtask

  // Compare captured beats with the MS-nibble-first expansion of exp_w.
  task automatic expect_words(input string tag);
    logic [15:0] w;
    int n;
    n = exp_w.size() * 4;
    check({tag, "_beat_count"}, 32'(beats.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < beats.size()) begin
        w = exp_w[i / 4];
        check({tag, "_beat"}, 32'(beats[i]), 32'(w[(3 - (i % 4)) * 4 +: 4]));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    classification = 1'b0;
    num_outputs_m1 = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_sending), 32'd0);
    // start in the reset cycle must be overridden
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    check("start_with_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("start_with_rst_idle", 32'(busy), 32'd0);

    // Non-classification, N=2
    mem[0] = 16'h1234; mem[1] = 16'hABCD;
    run_job(1'b0, 1, 1'b0, 0);
    exp_w.delete(); exp_w.push_back(16'h1234); exp_w.push_back(16'hABCD);
    expect_words("t1");
    check("t1_first_valid", 32'(first_valid), 32'd3);
    check("t1_n_rd", 32'(n_rd), 32'd2);
    check("t1_last_addr", 32'(last_addr), 32'd1);

    // Classification, N=4, tie keeps lowest index
    mem[0] = 16'h0005; mem[1] = 16'hFFFD; mem[2] = 16'h7FFF; mem[3] = 16'h7FFF;
    run_job(1'b1, 3, 1'b0, 0);
    exp_w.delete(); exp_w.push_back(16'h0002);
    expect_words("t2");
    check("t2_first_valid", 32'(first_valid), 32'd6);
    check("t2_first_rd", 32'(first_rd), 32'd1);
    check("t2_last_rd", 32'(last_rd), 32'd4);
    check("t2_n_rd", 32'(n_rd), 32'd4);

    // Backpressure on the first job
    mem[0] = 16'h1234; mem[1] = 16'hABCD;
    run_job(1'b0, 1, 1'b1, 0);
    exp_w.delete(); exp_w.push_back(16'h1234); exp_w.push_back(16'hABCD);
    expect_words("t3");
    check("t3_first_valid", 32'(first_valid), 32'd3);

    // Negative values, classification N=3
    mem[0] = 16'h8000; mem[1] = 16'hFFFF; mem[2] = 16'hFFFE;
    run_job(1'b1, 2, 1'b0, 0);
    exp_w.delete(); exp_w.push_back(16'h0001);
    expect_words("t4");
    check("t4_n_rd", 32'(n_rd), 32'd3);

    // Classification N=1: index 0
    mem[0] = 16'h8000;
    run_job(1'b1, 0, 1'b0, 0);
    exp_w.delete(); exp_w.push_back(16'h0000);
    expect_words("t5");
    check("t5_first_valid", 32'(first_valid), 32'd3);

    // Maximum N with a start pulse while busy
    exp_w.delete();
    for (int i = 0; i < 64; i++) begin
      mem[i] = 16'($urandom);
      exp_w.push_back(mem[i]);
    end
    run_job(1'b0, 63, 1'b1, 10);
    expect_words("t6");
    check("t6_n_rd", 32'(n_rd), 32'd64);
    check("t6_last_addr", 32'(last_addr), 32'd63);

    // Reset in the middle of SHIFT
    mem[0] = 16'h1234; mem[1] = 16'hABCD;
    classification = 1'b0;
    num_outputs_m1 = 6'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("t7_in_shift", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t7_rst_valid", 32'(out_valid), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_done", 32'(done_sending), 32'd0);
    check("t7_rst_rd_en", 32'(rd_en), 32'd0);
    n_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_sending) n_done++;
    end
    check("t7_no_done", 32'(n_done), 32'd0);
    check("t7_idle_busy", 32'(busy), 32'd0);
    mem[0] = 16'h5A3C;
    run_job(1'b0, 0, 1'b0, 0);
    exp_w.delete(); exp_w.push_back(16'h5A3C);
    expect_words("t7");
    check("t7_first_valid", 32'(first_valid), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
